wb_master_if: RTL
=================

Name: wb_master_if

Overview:
- Wishbone B3 classic initiator that turns the CPU pipeline's single-access memory requests (IF or MEM stage) into Wishbone cycles toward the crossbar master port.
- The CPU core instantiates it twice, once for the instruction bus and once for the data bus.
- It holds the pipeline via a stall request until the slave acks.
- It buffers returned read data while the pipeline is frozen by another stall source.

Parameters:
- ADDR_W, 32, Wishbone/CPU address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8 is derived.
- TIMEOUT_CYCLES, 255, ack watchdog limit in BUSY (used only with WB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_ce_i  in  1  access request from pipeline stage
- cpu_we_i  in  1  1 = write
- cpu_addr_i  in  ADDR_W  byte address
- cpu_sel_i  in  SEL_W  byte lanes
- cpu_data_i  in  DATA_W  write data
- cpu_data_o  out  DATA_W  read data to pipeline
- stall_req_o  out  1  hold pipeline
- pipe_stall_i  in  1  consuming stage frozen by another source
- flush_i  in  1  exception/branch flush, abandon access
- wb_addr_o  out  ADDR_W
- wb_data_o  out  DATA_W
- wb_sel_o  out  SEL_W
- wb_we_o  out  1
- wb_stb_o  out  1
- wb_cyc_o  out  1
- wb_data_i  in  DATA_W
- wb_ack_i  in  1
- bus_err_o  out  1  one-cycle pulse on watchdog abort (tied 0 without WB_TIMEOUT_EN)

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is asynchronous and active-high. Reset forces state IDLE and drives all wb_* outputs to 0. Read buffer = 0, bus_err_o = 0.
- All wb_* outputs are registered. stall_req_o and cpu_data_o are combinational from state, inputs and buffer.
- IDLE:
  - stall_req_o = cpu_ce_i & ~flush_i.
  - cpu_data_o = 0.
  - On an edge with cpu_ce_i & ~flush_i: register addr/data/sel/we from the CPU, set cyc=stb=1, go to BUSY.
  - Earliest ack is the next cycle, so minimum latency is 2 cycles request-to-data.
- BUSY:
  - wb_* are held stable until ack.
  - If wb_ack_i & ~flush_i:
    - stall_req_o = 0 and cpu_data_o = wb_data_i in the same cycle.
    - On the edge: cyc=stb=0, we=0; latch wb_data_i into the buffer.
    - Next state is WAIT_STALL if pipe_stall_i, else IDLE.
  - If no ack: stall_req_o = 1 and cpu_data_o = 0.
  - flush_i (with or without ack): cyc=stb=0 on the edge, go to IDLE, data discarded, stall_req_o = 0 that cycle.
  - A late ack after the flush is ignored in IDLE.
- WAIT_STALL:
  - cpu_data_o = buffer and stall_req_o = 0.
  - Go to IDLE when ~pipe_stall_i or flush_i.
  - A new request is not launched from WAIT_STALL.
- Write cycles: cpu_data_o = 0. The ack is handled identically to a read.
- Back-to-back access: IDLE→BUSY→IDLE costs one idle bus cycle between accesses (cyc deasserts for ≥1 cycle). This is required by the crossbar arbiter.
- Other stall sources: pipe_stall_i asserted in IDLE does not block launching a request.
- Reset mid-cycle: the bus drops immediately and asynchronously. No ack is expected afterwards.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter (width sized to TIMEOUT_CYCLES) clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES without ack: cyc=stb=0, bus_err_o pulses 1 for one cycle, go to IDLE, stall_req_o = 0 that cycle, cpu_data_o = 0.
- When undefined: no counter is built, bus_err_o is constant 0, and BUSY waits indefinitely.

Decomposition:
- Shared package/defines:
  - State encoding WB_IDLE = 2'b00, WB_BUSY = 2'b01, WB_WAIT_STALL = 2'b10.
  - ZeroWord constant.
  - Default timeout value.
- No sub-module is required; the optional watchdog is an inline counter.

Test Plan:
1. Read: ce=1, addr=0x0000_0100, slave acks 3 cycles after stb with data 0xDEADBEEF -> stall_req_o high 3 cycles, cpu_data_o = 0xDEADBEEF in the ack cycle, cyc low next cycle.
2. Write: we=1, sel=4'b0011, data=0x1234_5678 -> wb_* match on the cycle after request and stay stable until ack; cpu_data_o = 0.
3. Flush: flush_i in BUSY before ack -> cyc/stb low next edge, state IDLE; ack arriving 2 cycles later is ignored with no stall.
4. Frozen pipeline: ack with pipe_stall_i=1 and data 0xA5A5_A5A5 -> WAIT_STALL holds cpu_data_o = 0xA5A5_A5A5 for 4 stalled cycles, then IDLE when pipe_stall_i drops.
5. Watchdog (WB_TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack -> bus_err_o single pulse after 8 BUSY cycles, cyc=0, stall_req_o=0.
6. Reset mid-BUSY: rst asserted between edges -> wb_cyc_o/stb_o go 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/wb_master_if_pkg.sv
// Shared definitions for the Wishbone B3 classic initiator: state encoding,
// the all-zero data word and the default ack watchdog limit.
`timescale 1ns/1ps
package wb_master_if_pkg;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'b00,
        WB_BUSY       = 2'b01,
        WB_WAIT_STALL = 2'b10
    } wb_state_e;

    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam int          DefaultTimeout = 255;

endpackage

// File: rtl/wb_master_if.sv
// Wishbone B3 classic initiator for one CPU pipeline port (instruction or data bus).
// Optional ack watchdog is built only when the macro WB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
import wb_master_if_pkg::*;

module wb_master_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DefaultTimeout
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [DATA_W/8-1:0]   cpu_sel_i,
    input  logic [DATA_W-1:0]     cpu_data_i,
    output logic [DATA_W-1:0]     cpu_data_o,
    output logic                  stall_req_o,
    input  logic                  pipe_stall_i,
    input  logic                  flush_i,
    output logic [ADDR_W-1:0]     wb_addr_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic [DATA_W/8-1:0]   wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic                  wb_ack_i,
    output logic                  bus_err_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] ZeroData = DATA_W'(ZeroWord);

    wb_state_e           r_state;
    logic [ADDR_W-1:0]   r_wbAddr;
    logic [DATA_W-1:0]   r_wbData;
    logic [SEL_W-1:0]    r_wbSel;
    logic                r_wbWe;
    logic                r_wbStb;
    logic                r_wbCyc;
    logic [DATA_W-1:0]   r_readBuf;

    logic                w_reqValid;
    logic                w_ackTaken;
    logic                w_timeout;

    assign w_reqValid = cpu_ce_i & ~flush_i;
    assign w_ackTaken = (r_state == WB_BUSY) & wb_ack_i & ~flush_i;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0]    r_waitCount;
    logic                r_busErr;

    // Abort fires in the BUSY cycle that would make the ack-less count reach the limit
    assign w_timeout = (r_state == WB_BUSY) & ~wb_ack_i & ~flush_i &
                       (r_waitCount == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = r_busErr;
`else
    assign w_timeout = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    assign wb_addr_o = r_wbAddr;
    assign wb_data_o = r_wbData;
    assign wb_sel_o  = r_wbSel;
    assign wb_we_o   = r_wbWe;
    assign wb_stb_o  = r_wbStb;
    assign wb_cyc_o  = r_wbCyc;

    always_comb begin
        stall_req_o = 1'b0;
        cpu_data_o  = ZeroData;
        case (r_state)
            WB_IDLE: begin
                stall_req_o = w_reqValid;
            end
            WB_BUSY: begin
                if (w_ackTaken) begin
                    cpu_data_o = r_wbWe ? ZeroData : wb_data_i;
                end else if (!flush_i && !w_timeout) begin
                    stall_req_o = 1'b1;
                end
            end
            WB_WAIT_STALL: begin
                cpu_data_o = r_readBuf;
            end
            default: begin
                stall_req_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= WB_IDLE;
            r_wbAddr  <= '0;
            r_wbData  <= '0;
            r_wbSel   <= '0;
            r_wbWe    <= 1'b0;
            r_wbStb   <= 1'b0;
            r_wbCyc   <= 1'b0;
            r_readBuf <= '0;
`ifdef WB_TIMEOUT_EN
            r_waitCount <= '0;
            r_busErr    <= 1'b0;
`endif
        end else begin
`ifdef WB_TIMEOUT_EN
            r_busErr <= 1'b0;
`endif
            case (r_state)
                WB_IDLE: begin
                    if (w_reqValid) begin
                        r_wbAddr <= cpu_addr_i;
                        r_wbData <= cpu_data_i;
                        r_wbSel  <= cpu_sel_i;
                        r_wbWe   <= cpu_we_i;
                        r_wbStb  <= 1'b1;
                        r_wbCyc  <= 1'b1;
                        r_state  <= WB_BUSY;
`ifdef WB_TIMEOUT_EN
                        r_waitCount <= '0;
`endif
                    end
                end
                WB_BUSY: begin
                    if (flush_i) begin
                        r_wbCyc <= 1'b0;
                        r_wbStb <= 1'b0;
                        r_wbWe  <= 1'b0;
                        r_state <= WB_IDLE;
                    end else if (wb_ack_i) begin
                        r_wbCyc   <= 1'b0;
                        r_wbStb   <= 1'b0;
                        r_wbWe    <= 1'b0;
                        // Write acks leave an all-zero buffer so a frozen stage never sees stale read data
                        r_readBuf <= r_wbWe ? ZeroData : wb_data_i;
                        r_state   <= pipe_stall_i ? WB_WAIT_STALL : WB_IDLE;
                    end else if (w_timeout) begin
                        r_wbCyc <= 1'b0;
                        r_wbStb <= 1'b0;
                        r_wbWe  <= 1'b0;
                        r_state <= WB_IDLE;
`ifdef WB_TIMEOUT_EN
                        r_busErr <= 1'b1;
`endif
                    end else begin
`ifdef WB_TIMEOUT_EN
                        r_waitCount <= r_waitCount + 1'b1;
`endif
                    end
                end
                WB_WAIT_STALL: begin
                    if (!pipe_stall_i || flush_i) begin
                        r_state <= WB_IDLE;
                    end
                end
                default: begin
                    r_state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule
